// File: rtl/uart_gpio_loader.sv
// 8N1 UART receiver feeding the GPIO output register: each well-framed byte
// becomes a one-cycle write strobe with its data; bad stop bits pulse frame_err.
module uart_gpio_loader #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rx,
    output logic       we,
    output logic [7:0] wdata,
    output logic       frame_err,
    output logic       busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic            rx_m, rx_s;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            half_done, bit_done;
    logic            we_nxt, ferr_nxt, cnt_clr, shift_en, idx_clr;

    // Synchronizer flops reset high so a reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign half_done = (cnt == HALF_M1);
    assign bit_done  = (cnt == BIT_M1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!rx_s) state_nxt = START;
            START:     if (half_done) state_nxt = rx_s ? IDLE : DATA;
            DATA:      if (bit_done && bit_idx == 3'd7) state_nxt = STOP;
            STOP:      if (bit_done) state_nxt = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (!en) state_nxt = IDLE;
    end

    always_comb begin
        we_nxt   = 1'b0;
        ferr_nxt = 1'b0;
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        idx_clr  = 1'b0;
        case (state)
            IDLE:      cnt_clr = 1'b1;
            START: begin
                cnt_clr = half_done;
                idx_clr = 1'b1;
            end
            DATA: begin
                cnt_clr  = bit_done;
                shift_en = bit_done;
            end
            STOP: begin
                cnt_clr  = bit_done;
                we_nxt   = bit_done && rx_s;
                ferr_nxt = bit_done && !rx_s;
            end
            default:   cnt_clr = 1'b1;
        endcase
        if (!en) begin
            we_nxt   = 1'b0;
            ferr_nxt = 1'b0;
            cnt_clr  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CW'(1);
            if (idx_clr)       bit_idx <= '0;
            else if (shift_en) bit_idx <= bit_idx + 3'd1;
        end
    end

    // LSB arrives first, so shifting in at the MSB leaves bit i in position i.
    always_ff @(posedge clk) begin
        if (shift_en) shreg <= {rx_s, shreg[7:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we        <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            wdata     <= 8'h00;
        end else begin
            we        <= we_nxt;
            frame_err <= ferr_nxt;
            busy      <= (state_nxt != IDLE);
            if (we_nxt) wdata <= shreg;
        end
    end

endmodule

// File: tb/tb_uart_gpio_loader.sv
// Directed bench for uart_gpio_loader at 16 clocks per bit; frame timing is
// tracked in posedge counts from the cycle the start bit is driven.
module tb_uart_gpio_loader;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst, en, rx;
    logic       we, frame_err, busy;
    logic [7:0] wdata;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;
    int         we_q[$];
    logic [7:0] wd_q[$];
    int         fe_q[$];
    int         both = 0;
    int         busy_rise = -1;
    int         busy_fall = -1;
    logic       busy_d = 1'b0;

    uart_gpio_loader #(.CLKS_PER_BIT(N)) dut (
        .clk(clk), .rst(rst), .en(en), .rx(rx),
        .we(we), .wdata(wdata), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we) begin
            we_q.push_back(cyc);
            wd_q.push_back(wdata);
        end
        if (frame_err) fe_q.push_back(cyc);
        if (we && frame_err) both++;
        if (busy && !busy_d) busy_rise = cyc;
        if (!busy && busy_d) busy_fall = cyc;
        busy_d = busy;
    end

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        wait_cyc(N);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(N);
        end
        rx = stop;
        wait_cyc(N);
    endtask

    initial begin
        int c, n0, nf, bad;
        rst = 1'b1; en = 1'b1; rx = 1'b1;
        wait_cyc(3);
        check("rst_we", we, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", busy, 0);
        check("rst_wdata", wdata, 8'h00);

        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (we || frame_err || busy || wdata != 8'h00) bad++;
        end
        check("idle_quiet", bad, 0);

        // Single frame 0xA5
        c = cyc; n0 = we_q.size();
        send_frame(8'hA5, 1'b1);
        wait_cyc(5);
        check("a5_count", we_q.size(), n0 + 1);
        if (we_q.size() > n0) begin
            check("a5_we_edge", we_q[n0], c + 155);
            check("a5_wd_at_we", wd_q[n0], 8'hA5);
        end
        check("a5_wdata", wdata, 8'hA5);
        check("a5_busy_rise", busy_rise, c + 3);
        check("a5_busy_fall", busy_fall, c + 155);

        // Back-to-back 0x3C, 0xFF
        wait_cyc(20);
        c = cyc; n0 = we_q.size();
        send_frame(8'h3C, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_cyc(5);
        check("b2b_count", we_q.size(), n0 + 2);
        if (we_q.size() > n0 + 1) begin
            check("b2b_first_edge", we_q[n0], c + 155);
            check("b2b_spacing", we_q[n0+1] - we_q[n0], 160);
            check("b2b_wd0", wd_q[n0], 8'h3C);
            check("b2b_wd1", wd_q[n0+1], 8'hFF);
        end
        check("b2b_wdata", wdata, 8'hFF);

        // Framing error on 0x12, line held low afterwards
        wait_cyc(20);
        c = cyc; n0 = we_q.size(); nf = fe_q.size();
        send_frame(8'h12, 1'b0);
        wait_cyc(40);
        check("ferr_busy_hold", busy, 1);
        rx = 1'b1;
        wait_cyc(5);
        check("ferr_busy_drop", busy, 0);
        check("ferr_count", fe_q.size(), nf + 1);
        if (fe_q.size() > nf) check("ferr_edge", fe_q[nf], c + 155);
        check("ferr_no_we", we_q.size(), n0);
        check("ferr_wdata_kept", wdata, 8'hFF);
        wait_cyc(10);
        send_frame(8'h34, 1'b1);
        wait_cyc(5);
        check("after_ferr_count", we_q.size(), n0 + 1);
        check("after_ferr_wdata", wdata, 8'h34);

        // False start: 3-cycle glitch, START abandoned at the start-bit sample
        wait_cyc(20);
        c = cyc; n0 = we_q.size(); nf = fe_q.size();
        rx = 1'b0;
        wait_cyc(3);
        rx = 1'b1;
        wait_cyc(c + 10 - cyc);
        check("glitch_busy_in_start", busy, 1);
        wait_cyc(1);
        check("glitch_busy_idle", busy, 0);
        wait_cyc(200);
        check("glitch_no_we", we_q.size(), n0);
        check("glitch_no_ferr", fe_q.size(), nf);

        // Abort via en during data bit 4, then resend 0x5A
        n0 = we_q.size(); nf = fe_q.size();
        rx = 1'b0;
        wait_cyc(N);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h5A >> i) & 1;
            wait_cyc(N);
        end
        rx = 1'b1;
        wait_cyc(N / 2);
        check("abort_busy_before", busy, 1);
        en = 1'b0;
        wait_cyc(1);
        check("abort_busy_after", busy, 0);
        wait_cyc(200);
        en = 1'b1;
        wait_cyc(20);
        check("abort_no_we", we_q.size(), n0);
        check("abort_no_ferr", fe_q.size(), nf);
        send_frame(8'h5A, 1'b1);
        wait_cyc(5);
        check("resend_count", we_q.size(), n0 + 1);
        check("resend_wdata", wdata, 8'h5A);

        // Reset pulsed mid-frame clears outputs at once
        wait_cyc(20);
        n0 = we_q.size();
        rx = 1'b0;
        wait_cyc(N);
        rx = 1'b1;
        wait_cyc(N * 2);
        check("rstmid_busy_before", busy, 1);
        #1 rst = 1'b1;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_wdata", wdata, 8'h00);
        check("rstmid_we", we, 0);
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(200);
        check("rstmid_no_we", we_q.size(), n0);
        check("rstmid_idle_wdata", wdata, 8'h00);
        send_frame(8'h81, 1'b1);
        wait_cyc(5);
        check("post_rst_count", we_q.size(), n0 + 1);
        check("post_rst_wdata", wdata, 8'h81);

        check("we_ferr_exclusive", both, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
